cpu_rst_seq: RTL and testbench
==============================

# cpu_rst_seq

Reset sequencer that sits directly downstream of the CPU PLL. Clocked from the free-running 50 MHz board reference, it synchronises the PLL `locked` flag, drives the PLL reset, and releases `sys_rst_n` only after lock has been stable for a programmable time. It retries relock a bounded number of times and then latches a fault. `sys_rst_n` is re-synchronised into the 70 MHz CPU domain by the consumer, not by this block.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16: clocks `pll_rst` is held high per PLL reset pulse (≥1).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronised-locked clocks required before release (≥1).
- `LOCK_TIMEOUT_CYCLES`, 50000: clocks to wait for lock after a PLL reset pulse (1 ms at 50 MHz).
- `MAX_RETRIES`, 3: relock attempts allowed after timeouts before `fault`.

Ports:
- `clk`: in, 1. 50 MHz reference clock; the same net that feeds the PLL `refclk`.
- `rst_n`: in, 1. Reset, asynchronous active-low.
- `locked`: in, 1. PLL lock flag. Asynchronous to `clk`.
- `pll_rst`: out, 1. Active-high reset to the PLL.
- `sys_rst_n`: out, 1. Active-low system reset.
- `fault`: out, 1. Sticky relock failure.
- `retry_cnt`: out, $clog2(MAX_RETRIES+1). Number of timeouts since the last RUN.

## Operation
- `locked` passes through a 2-flop synchroniser; its output is `locked_s`. Only `locked_s` is used internally.
- All outputs are registered.
- Reset values: `pll_rst`=1, `sys_rst_n`=0, `fault`=0, `retry_cnt`=0, state=PLL_RESET, counters=0.
- **PLL_RESET**: `pll_rst`=1, `sys_rst_n`=0. After `PLL_RST_CYCLES` clocks, go to WAIT_LOCK and clear the counter.
- **WAIT_LOCK**: `pll_rst`=0. The counter increments each clock.
  - `locked_s`=1: go to STABILIZE and clear the counter.
  - Counter reaches `LOCK_TIMEOUT_CYCLES` with `retry_cnt`<`MAX_RETRIES`: increment `retry_cnt`, go to PLL_RESET.
  - Counter reaches `LOCK_TIMEOUT_CYCLES` otherwise: go to FAULT.
- **STABILIZE**:
  - `locked_s`=0: go to WAIT_LOCK with the timeout counter cleared.
  - Counter reaches `LOCK_STABLE_CYCLES`: go to RUN.
- **RUN**: `sys_rst_n`=1 and `retry_cnt` clears to 0. `locked_s`=0 drives `sys_rst_n` to 0 on the next edge and sends the FSM to PLL_RESET. A lock loss in RUN does not count as a retry.
- **FAULT**: `fault`=1, `pll_rst`=0, `sys_rst_n`=0. Exit only via `rst_n`.
- A 1-cycle `locked` glitch during STABILIZE that reaches `locked_s` restarts stabilisation.
- Counter width is sized for the maximum of all count parameters. Counters never wrap; the compare is ≥.

## Timing
- `rst_n` assertion forces all outputs to their reset values immediately and asynchronously. Deassertion is clocked: the first edge after release starts PLL_RESET counting.
- `pll_rst` is high for exactly `PLL_RST_CYCLES` clocks after `rst_n` release and for every retry pulse.
- If `locked` rises before edge N and stays high, `sys_rst_n` rises at edge N+`LOCK_STABLE_CYCLES`+3.
- Lock loss in RUN: `sys_rst_n` falls 3 edges after `locked` falls (2 synchroniser edges plus 1 register edge). `pll_rst` rises on the same edge.
- Timeout-to-`pll_rst` latency is 1 clock.

## Configuration
- `CPU_RST_SEQ_STATUS_EN` defined: adds output `lock_loss_cnt` [7:0]. It increments (saturating at 255) on each RUN→PLL_RESET transition and resets to 0 only on `rst_n`.
- Undefined: no such port or logic exists.

## Structure
- Package `cpu_rst_seq_pkg` holds:
  - the state enum (PLL_RESET, WAIT_LOCK, STABILIZE, RUN, FAULT);
  - the default parameter constants;
  - the counter-width function.
- One sub-module, `sync_2ff`: a single-bit 2-flop synchroniser with asynchronous active-low reset to 0. It is used for `locked`.

## Test plan
Bench parameters: `PLL_RST_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=32, `MAX_RETRIES`=2.
- **Clean start.** Release `rst_n`; `locked` rises at edge 10 → `pll_rst` high for edges 1–4; `sys_rst_n` rises at edge 21; `retry_cnt`=0.
- **Glitch in STABILIZE.** `locked` drops for 2 clocks at 5 clocks into STABILIZE → counter restarts; `sys_rst_n` rises 11 edges after `locked` returns.
- **Lock loss in RUN.** Drop `locked` → `sys_rst_n`=0 and `pll_rst`=1 after 3 edges; the full sequence repeats; with the macro set, `lock_loss_cnt`=1.
- **Timeouts to fault.** `locked` held 0 → `retry_cnt` steps 1, 2; after the third timeout `fault`=1, `pll_rst`=0, `sys_rst_n`=0, and these hold for 1000 clocks.
- **Reset mid-operation.** Assert `rst_n` low during STABILIZE and during FAULT → outputs take reset values within the same cycle; release restarts from PLL_RESET with `fault`=0.
- **Retry count clears.** Lock on the second attempt (`retry_cnt`=1) → entering RUN clears `retry_cnt` to 0.

Source files
------------

// File: rtl/cpu_rst_seq_pkg.sv
// ---------------------------------------------------------------------------
// cpu_rst_seq_pkg
//
// Purpose:
//   Shared definitions for the CPU PLL reset sequencer: the sequencer state
//   encoding, the default timing constants and the helper that sizes the
//   shared cycle counter.
//
// Contents:
//   state_t              - sequencer states (PLL_RESET, WAIT_LOCK, STABILIZE,
//                          RUN, FAULT)
//   DEF_*                - default values for the cpu_rst_seq parameters
//   cnt_width()          - bit width able to hold the largest count parameter
// ---------------------------------------------------------------------------
package cpu_rst_seq_pkg;

    // Sequencer states. The reset value is PLL_RESET.
    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    // Default timing for a 50 MHz reference clock.
    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
    localparam int DEF_MAX_RETRIES         = 3;

    // One counter is shared by every timed state, so it has to hold the
    // largest of the three count parameters without wrapping.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m < 1) m = 1;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/cpu_rst_seq_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//
// Purpose:
//   Single-bit two-flop synchroniser. Brings an asynchronous level into the
//   clk domain. Both flops clear to 0 on reset, so an asynchronous input is
//   seen as deasserted until it has been sampled twice after reset release.
//
// Ports:
//   clk    in  1  destination clock
//   rst_n  in  1  asynchronous active-low reset
//   i_d    in  1  asynchronous input level
//   o_q    out 1  synchronised level, two clk edges of latency
// ---------------------------------------------------------------------------
module sync_2ff
    import cpu_rst_seq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // First flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/cpu_rst_seq.sv
// ---------------------------------------------------------------------------
// cpu_rst_seq
//
// Purpose:
//   Reset sequencer sitting directly downstream of the CPU PLL. Runs from the
//   free-running 50 MHz board reference (the same net as the PLL refclk),
//   pulses the PLL reset, waits for lock, requires lock to stay up for a
//   programmable time and only then releases the system reset. Lock
//   timeouts are retried a bounded number of times before a sticky fault is
//   raised. sys_rst_n is NOT synchronised to the 70 MHz CPU domain here; the
//   consumer does that.
//
// Parameters:
//   PLL_RST_CYCLES      clocks pll_rst is held high per pulse (>= 1)
//   LOCK_STABLE_CYCLES  consecutive locked clocks required before release (>= 1)
//   LOCK_TIMEOUT_CYCLES clocks to wait for lock after a PLL reset pulse (>= 1)
//   MAX_RETRIES         relock attempts after timeouts before fault (>= 1)
//
// Ports:
//   clk            in  1   50 MHz reference clock
//   rst_n          in  1   asynchronous active-low reset
//   locked         in  1   PLL lock flag, asynchronous to clk
//   pll_rst        out 1   active-high reset to the PLL
//   sys_rst_n      out 1   active-low system reset
//   fault          out 1   sticky relock failure, cleared only by rst_n
//   retry_cnt      out RW  timeouts since the last entry into RUN
//   lock_loss_cnt  out 8   (only with CPU_RST_SEQ_STATUS_EN) saturating count
//                          of lock losses while running
//
// Configuration:
//   CPU_RST_SEQ_STATUS_EN  when defined, adds the lock_loss_cnt status port.
//                          Undefined by default: no port and no logic.
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module cpu_rst_seq
    import cpu_rst_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
)
(
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               locked,
    output logic                               pll_rst,
    output logic                               sys_rst_n,
    output logic                               fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
`ifdef CPU_RST_SEQ_STATUS_EN
    ,
    output logic [7:0]                         lock_loss_cnt
`endif
);

    localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    // Terminal counts. The counter is cleared on the edge that enters a
    // state, so PLL_RESET and WAIT_LOCK leave on the edge where the counter
    // shows N-1, giving exactly N clocks in the state. STABILIZE compares
    // against the full count because the edge that first sees locked_s is
    // spent entering it.
    localparam logic [CW-1:0] C_PLL_LAST     = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] C_STABLE       = CW'(LOCK_STABLE_CYCLES);
    localparam logic [CW-1:0] C_TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] C_MAX_RETRY    = RW'(MAX_RETRIES);

    logic          w_locked_s;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_pll_rst;
    logic          r_sys_rst_n;
    logic          r_fault;
    logic [RW-1:0] r_retry;

    // The raw lock flag comes from the PLL's own clock domain; nothing below
    // looks at it directly.
    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (locked),
        .o_q   (w_locked_s)
    );

    // Main sequencer. Outputs are updated on the same edge as the state
    // transition that implies them, so each output is a plain flop and no
    // decode sits between the state register and the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= PLL_RESET;
            r_cnt       <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_fault     <= 1'b0;
            r_retry     <= '0;
        end else begin
            case (r_state)
                PLL_RESET: begin
                    r_pll_rst   <= 1'b1;
                    r_sys_rst_n <= 1'b0;
                    if (r_cnt >= C_PLL_LAST) begin
                        r_state   <= WAIT_LOCK;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                WAIT_LOCK: begin
                    if (w_locked_s) begin
                        r_state <= STABILIZE;
                        r_cnt   <= '0;
                    end else if (r_cnt >= C_TIMEOUT_LAST) begin
                        r_cnt <= '0;
                        if (r_retry < C_MAX_RETRY) begin
                            r_retry   <= r_retry + 1'b1;
                            r_state   <= PLL_RESET;
                            r_pll_rst <= 1'b1;
                        end else begin
                            r_state     <= FAULT;
                            r_fault     <= 1'b1;
                            r_pll_rst   <= 1'b0;
                            r_sys_rst_n <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                STABILIZE: begin
                    // Any dropout, even a single synchronised cycle, throws
                    // away the stability credit collected so far.
                    if (!w_locked_s) begin
                        r_state <= WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt >= C_STABLE) begin
                        r_state     <= RUN;
                        r_cnt       <= '0;
                        r_sys_rst_n <= 1'b1;
                        r_retry     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                RUN: begin
                    // Lock loss while running restarts the whole sequence but
                    // is not a timeout, so the retry budget is untouched.
                    if (!w_locked_s) begin
                        r_state     <= PLL_RESET;
                        r_cnt       <= '0;
                        r_sys_rst_n <= 1'b0;
                        r_pll_rst   <= 1'b1;
                    end
                end

                FAULT: begin
                    r_fault     <= 1'b1;
                    r_pll_rst   <= 1'b0;
                    r_sys_rst_n <= 1'b0;
                end

                default: begin
                    r_state     <= PLL_RESET;
                    r_cnt       <= '0;
                    r_pll_rst   <= 1'b1;
                    r_sys_rst_n <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst   = r_pll_rst;
    assign sys_rst_n = r_sys_rst_n;
    assign fault     = r_fault;
    assign retry_cnt = r_retry;

`ifdef CPU_RST_SEQ_STATUS_EN
    logic [7:0] r_lock_loss;

    // Counts RUN -> PLL_RESET transitions; saturates rather than wrapping so
    // a flapping PLL never reads back as healthy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_loss <= 8'd0;
        end else if ((r_state == RUN) && !w_locked_s && (r_lock_loss != 8'hFF)) begin
            r_lock_loss <= r_lock_loss + 8'd1;
        end
    end

    assign lock_loss_cnt = r_lock_loss;
`endif

endmodule

// File: tb/tb_cpu_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_cpu_rst_seq
//
// Self-checking bench for cpu_rst_seq. Each segment releases rst_n, drives a
// precomputed locked waveform edge by edge, and ends with an asynchronous
// reset mid-cycle. Before a segment starts, a behavioural model turns the
// waveform into the list of edges where the outputs should change; a
// negedge monitor pops that list whenever the DUT outputs change.
// ---------------------------------------------------------------------------
module tb_cpu_rst_seq;

    localparam int P_PLL     = 4;
    localparam int P_STABLE  = 8;
    localparam int P_TIMEOUT = 32;
    localparam int P_RETRIES = 2;
    localparam int SEQ_MAX   = 1200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       locked = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       fault;
    logic [1:0] retry_cnt;
`ifdef CPU_RST_SEQ_STATUS_EN
    logic [7:0] lock_loss_cnt;
`endif

    always #5 clk = ~clk;

    cpu_rst_seq #(
        .PLL_RST_CYCLES      (P_PLL),
        .LOCK_STABLE_CYCLES  (P_STABLE),
        .LOCK_TIMEOUT_CYCLES (P_TIMEOUT),
        .MAX_RETRIES         (P_RETRIES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .locked        (locked),
        .pll_rst       (pll_rst),
        .sys_rst_n     (sys_rst_n),
        .fault         (fault),
        .retry_cnt     (retry_cnt)
`ifdef CPU_RST_SEQ_STATUS_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    typedef struct {
        int edgeN;
        bit pll;
        bit sys;
        bit flt;
        int retry;
    } evt_t;

    evt_t expQ[$];
    bit   lockSeq [0:SEQ_MAX-1];

    int   checks = 0;
    int   failures = 0;
    int   edgeNum = 0;
    int   segBase = 0;
    int   segId = 0;
    int   monSeg = -1;
    bit   active = 1'b0;

    logic [4:0] lastSample;
    logic [4:0] curSample;
    int         monEdge;
    evt_t       monExp;

    int sysRise[$];
    int sysFall[$];
    int pllRise[$];
    int pllFall[$];
    int faultRise[$];
    int retryUp[$];

    bit expPll;
    bit expSys;
    bit expFault;
    int expRetry;
    int expLoss;

    always @(posedge clk) edgeNum++;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Behavioural model: walks the synchronised lock level edge by edge and
    // applies the sequencing rules using the edge at which each phase began.
    task automatic runModel(input int L);
        string phase;
        int    since;
        int    tries;
        bit    p;
        bit    s;
        bit    f;
        int    loss;
        phase = "reset";
        since = 0;
        tries = 0;
        p = 1'b1;
        s = 1'b0;
        f = 1'b0;
        loss = 0;
        expQ.delete();
        for (int e = 1; e <= L; e++) begin
            bit ls;
            bit pp;
            bit ps;
            bit pf;
            int pt;
            int age;
            ls  = (e >= 3) ? lockSeq[e-2] : 1'b0;
            pp  = p;
            ps  = s;
            pf  = f;
            pt  = tries;
            age = e - since;
            if (phase == "reset") begin
                if (age == P_PLL) begin
                    phase = "waitLock"; since = e; p = 1'b0;
                end
            end else if (phase == "waitLock") begin
                if (ls) begin
                    phase = "settle"; since = e;
                end else if (age == P_TIMEOUT) begin
                    if (tries < P_RETRIES) begin
                        tries++; phase = "reset"; since = e; p = 1'b1;
                    end else begin
                        phase = "fault"; f = 1'b1; p = 1'b0; s = 1'b0;
                    end
                end
            end else if (phase == "settle") begin
                if (!ls) begin
                    phase = "waitLock"; since = e;
                end else if (age == P_STABLE + 1) begin
                    phase = "run"; s = 1'b1; tries = 0;
                end
            end else if (phase == "run") begin
                if (!ls) begin
                    phase = "reset"; since = e; s = 1'b0; p = 1'b1;
                    if (loss < 255) loss++;
                end
            end
            if (p != pp || s != ps || f != pf || tries != pt)
                expQ.push_back('{e, p, s, f, tries});
        end
        expPll   = p;
        expSys   = s;
        expFault = f;
        expRetry = tries;
        expLoss  = loss;
    endtask

    // Monitor: every output change must match the next predicted event.
    always @(negedge clk) begin
        if (active) begin
            if (monSeg != segId) begin
                monSeg     = segId;
                lastSample = 5'b10000;
            end
            curSample = {pll_rst, sys_rst_n, fault, retry_cnt};
            if (curSample !== lastSample) begin
                monEdge = edgeNum - segBase;
                if (sys_rst_n && !lastSample[3]) sysRise.push_back(monEdge);
                if (!sys_rst_n && lastSample[3]) sysFall.push_back(monEdge);
                if (pll_rst && !lastSample[4]) pllRise.push_back(monEdge);
                if (!pll_rst && lastSample[4]) pllFall.push_back(monEdge);
                if (fault && !lastSample[2]) faultRise.push_back(monEdge);
                if (retry_cnt > lastSample[1:0]) retryUp.push_back(monEdge);
                checks++;
                if (expQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected change: edge %0d pll=%0b sys=%0b fault=%0b retry=%0d, expected no change",
                             monEdge, pll_rst, sys_rst_n, fault, retry_cnt);
                end else begin
                    monExp = expQ.pop_front();
                    if (monExp.edgeN != monEdge || monExp.pll !== pll_rst || monExp.sys !== sys_rst_n ||
                        monExp.flt !== fault || monExp.retry != int'(retry_cnt)) begin
                        failures++;
                        $display("[TB] FAIL output event: got edge %0d pll=%0b sys=%0b fault=%0b retry=%0d, expected edge %0d pll=%0b sys=%0b fault=%0b retry=%0d",
                                 monEdge, pll_rst, sys_rst_n, fault, retry_cnt,
                                 monExp.edgeN, monExp.pll, monExp.sys, monExp.flt, monExp.retry);
                    end
                end
                lastSample = curSample;
            end
        end
    end

    // One segment: release reset, drive lockSeq[1..L], check the final state,
    // then assert rst_n mid-cycle and check the asynchronous reset values.
    task automatic applyStimulus(input string name, input int L);
        runModel(L);
        sysRise.delete(); sysFall.delete(); pllRise.delete();
        pllFall.delete(); faultRise.delete(); retryUp.delete();
        @(negedge clk);
        segId++;
        segBase = edgeNum;
        locked  = lockSeq[1];
        rst_n   = 1'b1;
        active  = 1'b1;
        for (int k = 1; k <= L; k++) begin
            locked = lockSeq[k];
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        checkOutput({name, " final outputs"}, int'({pll_rst, sys_rst_n, fault, retry_cnt}),
                    int'({expPll, expSys, expFault, 2'(expRetry)}));
`ifdef CPU_RST_SEQ_STATUS_EN
        checkOutput({name, " lock_loss_cnt"}, int'(lock_loss_cnt), expLoss);
`endif
        active = 1'b0;
        while (expQ.size() > 0) begin
            monExp = expQ.pop_front();
            checks++;
            failures++;
            $display("[TB] FAIL missing event in %s: no change seen, expected edge %0d pll=%0b sys=%0b fault=%0b retry=%0d",
                     name, monExp.edgeN, monExp.pll, monExp.sys, monExp.flt, monExp.retry);
        end
        rst_n = 1'b0;
        #1;
        checkOutput({name, " async reset"}, int'({pll_rst, sys_rst_n, fault, retry_cnt}), 16);
`ifdef CPU_RST_SEQ_STATUS_EN
        checkOutput({name, " async reset loss"}, int'(lock_loss_cnt), 0);
`endif
        locked = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic fillRandom();
        bit v;
        int k;
        v = 1'b0;
        k = 1;
        while (k < SEQ_MAX) begin
            int len;
            len = v ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 45));
            for (int j = 0; j < len && k < SEQ_MAX; j++) begin
                lockSeq[k] = v;
                k++;
            end
            v = ~v;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        $display("[TB] cpu_rst_seq bench start");
        rst_n  = 1'b0;
        locked = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("power-on reset", int'({pll_rst, sys_rst_n, fault, retry_cnt}), 16);

        // Clean start: locked rises before edge 10.
        for (int k = 0; k < SEQ_MAX; k++) lockSeq[k] = (k >= 10);
        applyStimulus("cleanStart", 40);
        checkOutput("cleanStart pll fall edge", (pllFall.size() > 0) ? pllFall[0] : -1, 4);
        checkOutput("cleanStart sys rise edge", (sysRise.size() > 0) ? sysRise[0] : -1, 21);

        // Two-clock dropout five clocks into STABILIZE; lock returns at edge 19.
        for (int k = 0; k < SEQ_MAX; k++) lockSeq[k] = (k >= 10) && !(k == 17 || k == 18);
        applyStimulus("glitch", 45);
        checkOutput("glitch sys rise edge", (sysRise.size() > 0) ? sysRise[0] : -1, 30);

        // Lock loss in RUN at edge 40 for five clocks.
        for (int k = 0; k < SEQ_MAX; k++) lockSeq[k] = (k >= 10) && !(k >= 40 && k <= 44);
        applyStimulus("runLoss", 70);
        checkOutput("runLoss sys fall edge", (sysFall.size() > 0) ? sysFall[0] : -1, 42);
        checkOutput("runLoss pll rise edge", (pllRise.size() > 0) ? pllRise[0] : -1, 42);
        checkOutput("runLoss second release edge", (sysRise.size() > 1) ? sysRise[1] : -1, 56);

        // No lock at all: two retries then fault, held for 1000 clocks.
        for (int k = 0; k < SEQ_MAX; k++) lockSeq[k] = 1'b0;
        applyStimulus("timeouts", 1110);
        checkOutput("timeouts first retry edge", (retryUp.size() > 0) ? retryUp[0] : -1, 36);
        checkOutput("timeouts second retry edge", (retryUp.size() > 1) ? retryUp[1] : -1, 72);
        checkOutput("timeouts fault edge", (faultRise.size() > 0) ? faultRise[0] : -1, 108);

        // Reset asserted while stabilising.
        for (int k = 0; k < SEQ_MAX; k++) lockSeq[k] = (k >= 10);
        applyStimulus("resetInSettle", 15);

        // Lock only on the second attempt; RUN clears the retry count.
        for (int k = 0; k < SEQ_MAX; k++) lockSeq[k] = (k >= 45);
        applyStimulus("retryClears", 70);
        checkOutput("retryClears retry edge", (retryUp.size() > 0) ? retryUp[0] : -1, 36);
        checkOutput("retryClears sys rise edge", (sysRise.size() > 0) ? sysRise[0] : -1, 56);

        for (int r = 0; r < 6; r++) begin
            fillRandom();
            applyStimulus("random", int'($urandom_range(150, 400)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
